// File: rtl/sys_pll_rst_ctrl.sv
// Reset and lock supervisor for the system PLL: sequences pll_rst, qualifies lock,
// releases sys_rst after stable lock, retries on timeout and latches a fault.
module sys_pll_rst_ctrl #(
  parameter int unsigned RST_CYCLES         = 16,
  parameter int unsigned LOCK_STABLE_CYCLES = 1024,
  parameter int unsigned LOCK_TIMEOUT       = 50000,
  parameter int unsigned MAX_RETRIES        = 3,
  parameter int unsigned CNT_W              = 16
) (
  input  logic       refclk,
  input  logic       rst,
  input  logic       pll_locked,
  output logic       pll_rst,
  output logic       sys_rst,
  output logic       ready,
  output logic       fail,
  output logic [7:0] lock_loss_cnt
);

  localparam int unsigned RETRY_W = (MAX_RETRIES < 1) ? 1 : $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   RST_LAST = CNT_W'(RST_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TMO_LAST = CNT_W'(LOCK_TIMEOUT - 1);
  localparam logic [RETRY_W-1:0] RETRY_MAX = RETRY_W'(MAX_RETRIES);

  typedef enum logic [2:0] {
    S_PLL_RST,
    S_WAIT_LOCK,
    S_STABLE,
    S_RUN,
    S_FAIL
  } state_e;

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [RETRY_W-1:0] retries_q, retries_d, retries_inc;
  logic [7:0]         loss_q, loss_d;
  logic               sync1_q, locked_s_q;
  logic               pll_rst_q, pll_rst_d;
  logic               sys_rst_q, sys_rst_d;
  logic               ready_q, ready_d;
  logic               fail_q, fail_d;

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q + 1'b1;
    retries_d   = retries_q;
    loss_d      = loss_q;
    retries_inc = retries_q + 1'b1;

    unique case (state_q)
      S_PLL_RST: begin
        if (cnt_q == RST_LAST) state_d = S_WAIT_LOCK;
      end
      S_WAIT_LOCK: begin
        // Lock takes priority over a coinciding timeout.
        if (locked_s_q) begin
          state_d = S_STABLE;
        end else if (cnt_q == TMO_LAST) begin
          retries_d = retries_inc;
          state_d   = (retries_inc == RETRY_MAX) ? S_FAIL : S_PLL_RST;
        end
      end
      S_STABLE: begin
        if (!locked_s_q) begin
          state_d = S_WAIT_LOCK;
        end else if (cnt_q == STB_LAST) begin
          state_d   = S_RUN;
          retries_d = '0;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q;
        if (!locked_s_q) begin
          state_d = S_PLL_RST;
          if (loss_q != '1) loss_d = loss_q + 1'b1;
        end
      end
      S_FAIL: begin
        cnt_d = cnt_q;
      end
      default: begin
        state_d = S_PLL_RST;
      end
    endcase

    if (state_d != state_q) cnt_d = '0;

    // Outputs are decoded from the next state so they register alongside it.
    pll_rst_d = (state_d == S_PLL_RST) || (state_d == S_FAIL);
    sys_rst_d = (state_d != S_RUN);
    ready_d   = (state_d == S_RUN);
    fail_d    = (state_d == S_FAIL);
  end

  always_ff @(posedge refclk or posedge rst) begin
    if (rst) begin
      state_q    <= S_PLL_RST;
      cnt_q      <= '0;
      retries_q  <= '0;
      loss_q     <= '0;
      sync1_q    <= 1'b0;
      locked_s_q <= 1'b0;
      pll_rst_q  <= 1'b1;
      sys_rst_q  <= 1'b1;
      ready_q    <= 1'b0;
      fail_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      retries_q  <= retries_d;
      loss_q     <= loss_d;
      sync1_q    <= pll_locked;
      locked_s_q <= sync1_q;
      pll_rst_q  <= pll_rst_d;
      sys_rst_q  <= sys_rst_d;
      ready_q    <= ready_d;
      fail_q     <= fail_d;
    end
  end

  assign pll_rst       = pll_rst_q;
  assign sys_rst       = sys_rst_q;
  assign ready         = ready_q;
  assign fail          = fail_q;
  assign lock_loss_cnt = loss_q;

endmodule

// File: tb/tb_sys_pll_rst_ctrl.sv
// Bench for sys_pll_rst_ctrl: directed scenarios plus random lock patterns, every
// cycle compared against a deadline-based behavioural model.
module tb_sys_pll_rst_ctrl;

  localparam int unsigned RSTC = 4;
  localparam int unsigned STB  = 8;
  localparam int unsigned TMO  = 20;
  localparam int unsigned MAXR = 2;

  logic       refclk = 1'b0;
  logic       rst;
  logic       pll_locked;
  logic       pll_rst, sys_rst, ready, fail;
  logic [7:0] lock_loss_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  always #10 refclk = ~refclk;

  sys_pll_rst_ctrl #(
    .RST_CYCLES        (RSTC),
    .LOCK_STABLE_CYCLES(STB),
    .LOCK_TIMEOUT      (TMO),
    .MAX_RETRIES       (MAXR),
    .CNT_W             (16)
  ) dut (
    .refclk       (refclk),
    .rst          (rst),
    .pll_locked   (pll_locked),
    .pll_rst      (pll_rst),
    .sys_rst      (sys_rst),
    .ready        (ready),
    .fail         (fail),
    .lock_loss_cnt(lock_loss_cnt)
  );

  // Reference model: phase plus absolute-edge deadlines.
  typedef enum {PH_PULSE, PH_WAIT, PH_STABLE, PH_RUN, PH_FAIL} phase_e;
  phase_e ph;
  longint edge_n = 0;
  longint deadline;
  int     tries, losses;
  bit     sh[2];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    ph       = PH_PULSE;
    deadline = edge_n + RSTC;
    tries    = 0;
    losses   = 0;
    sh[0]    = 1'b0;
    sh[1]    = 1'b0;
  endtask

  task automatic model_edge(input bit lk);
    bit ls;
    edge_n++;
    ls    = sh[1];
    sh[1] = sh[0];
    sh[0] = lk;
    case (ph)
      PH_PULSE:
        if (edge_n == deadline) begin ph = PH_WAIT; deadline = edge_n + TMO; end
      PH_WAIT:
        if (ls) begin
          ph = PH_STABLE; deadline = edge_n + STB;
        end else if (edge_n == deadline) begin
          tries++;
          if (tries == MAXR) ph = PH_FAIL;
          else begin ph = PH_PULSE; deadline = edge_n + RSTC; end
        end
      PH_STABLE:
        if (!ls) begin
          ph = PH_WAIT; deadline = edge_n + TMO;
        end else if (edge_n == deadline) begin
          ph = PH_RUN; tries = 0;
        end
      PH_RUN:
        if (!ls) begin
          ph = PH_PULSE; deadline = edge_n + RSTC;
          if (losses < 255) losses++;
        end
      default: ;
    endcase
  endtask

  task automatic compare_all();
    check_eq("pll_rst", pll_rst, (ph == PH_PULSE) || (ph == PH_FAIL));
    check_eq("sys_rst", sys_rst, ph != PH_RUN);
    check_eq("ready", ready, ph == PH_RUN);
    check_eq("fail", fail, ph == PH_FAIL);
    check_eq("lock_loss_cnt", lock_loss_cnt, losses);
  endtask

  task automatic step(input bit lk);
    pll_locked = lk;
    @(posedge refclk);
    #1;
    model_edge(lk);
    compare_all();
  endtask

  // Asserts rst between edges, checks the immediate output response, releases it.
  task automatic do_reset();
    #4;
    rst = 1'b1;
    #1;
    check_eq("async_pll_rst", pll_rst, 1);
    check_eq("async_sys_rst", sys_rst, 1);
    check_eq("async_ready", ready, 0);
    check_eq("async_fail", fail, 0);
    check_eq("async_lock_loss", lock_loss_cnt, 0);
    @(posedge refclk);
    @(posedge refclk);
    #1;
    rst = 1'b0;
    model_reset();
  endtask

  task automatic ones_until_ready(input string tag, input int done, input int exp);
    int k = done;
    while (!ready && k < 60) begin
      step(1'b1);
      k++;
    end
    check_eq(tag, k, exp);
  endtask

  task automatic lose_and_relock();
    step(1'b0);
    step(1'b1);
    check_eq("loss_sys_rst_early", sys_rst, 0);
    step(1'b1);
    check_eq("loss_sys_rst", sys_rst, 1);
    check_eq("loss_pll_rst", pll_rst, 1);
    check_eq("loss_ready", ready, 0);
    ones_until_ready("loss_recover_len", 2, 15);
  endtask

  initial begin
    #10_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int k;
    int unsigned len;
    bit lk;

    rst        = 1'b1;
    pll_locked = 1'b0;
    #5;
    model_reset();
    check_eq("reset_pll_rst", pll_rst, 1);
    check_eq("reset_sys_rst", sys_rst, 1);
    check_eq("reset_ready", ready, 0);
    check_eq("reset_fail", fail, 0);
    check_eq("reset_lock_loss", lock_loss_cnt, 0);
    @(posedge refclk);
    #1;
    rst = 1'b0;

    // Nominal bring-up
    k = 0;
    while (pll_rst && k < 50) begin
      step(1'b0);
      k++;
    end
    check_eq("pll_rst_width", k, RSTC);
    repeat (10) step(1'b0);
    ones_until_ready("lock_to_ready", 0, 2 + 1 + STB);
    check_eq("nominal_fail", fail, 0);

    // Lock glitch during STABLE
    do_reset();
    repeat (RSTC) step(1'b0);
    repeat (5) step(1'b1);
    step(1'b0);
    ones_until_ready("glitch_recover", 0, 2 + 1 + STB);

    // Timeout retry then success
    do_reset();
    repeat (RSTC + TMO) step(1'b0);
    check_eq("retry_pulse_start", pll_rst, 1);
    repeat (RSTC - 1) step(1'b0);
    check_eq("retry_pulse_hold", pll_rst, 1);
    step(1'b0);
    check_eq("retry_pulse_end", pll_rst, 0);
    ones_until_ready("retry_to_ready", 0, 2 + 1 + STB);
    check_eq("retry_fail", fail, 0);

    // Lock loss in RUN, three times
    repeat (3) lose_and_relock();
    check_eq("lock_loss_3", lock_loss_cnt, 3);

    // Persistent failure
    do_reset();
    repeat (MAXR * (RSTC + TMO)) step(1'b0);
    check_eq("fail_set", fail, 1);
    repeat (50) step(1'b0);
    repeat (20) step(1'b1);
    check_eq("fail_held", fail, 1);
    check_eq("fail_pll_rst", pll_rst, 1);
    check_eq("fail_sys_rst", sys_rst, 1);
    do_reset();
    check_eq("fail_cleared", fail, 0);
    repeat (RSTC) step(1'b0);
    check_eq("restart_pll_rst", pll_rst, 0);

    // Timeout coinciding with lock: lock wins and retries are kept
    do_reset();
    repeat (2 * RSTC + TMO + TMO - 3) step(1'b0);
    repeat (3) step(1'b1);
    check_eq("tie_lock_wins_pll_rst", pll_rst, 0);
    check_eq("tie_lock_wins_fail", fail, 0);
    repeat (3 + TMO) step(1'b0);
    check_eq("tie_retries_kept", fail, 1);

    // Random lock patterns
    do_reset();
    repeat (60) begin
      lk  = 1'($urandom_range(0, 1));
      len = $urandom_range(1, 25);
      repeat (len) step(lk);
      if ($urandom_range(0, 9) == 0) do_reset();
    end

    // Lock-loss counter saturation
    do_reset();
    repeat (RSTC) step(1'b0);
    ones_until_ready("sat_bringup", 0, 2 + 1 + STB);
    repeat (260) lose_and_relock();
    check_eq("lock_loss_sat", lock_loss_cnt, 255);

    // Async reset mid-STABLE
    step(1'b0);
    repeat (9) step(1'b1);
    check_eq("mid_stable_sys_rst", sys_rst, 1);
    check_eq("mid_stable_pll_rst", pll_rst, 0);
    do_reset();
    repeat (RSTC) step(1'b0);
    ones_until_ready("post_reset_ready", 0, 2 + 1 + STB);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
